uart16550_tx: RTL and testbench
===============================

UART16550_TX -- requirements
Module: uart16550_tx

Interface
REQ-001 SHALL have port: clk_i  input  1  system clock, rising edge; all state changes on this edge only.
REQ-002 SHALL have port: rst_i  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: baudout_i  input  1  16x baud enable, one clk_i cycle wide per tick.
REQ-004 SHALL have port: csr_i  input  csr_t  register set; uses lcr.wls, lcr.stb, lcr.pen, lcr.eps, lcr.stick_parity, lcr.bc.
REQ-005 SHALL have port: empty_i  input  1  TX FIFO/THR empty.
REQ-006 SHALL have port: d_i  input  8  TX FIFO head data (show-ahead), valid while empty_i=0.
REQ-007 SHALL have port: pop_o  output  1  one-cycle pop of the TX FIFO head.
REQ-008 SHALL have port: temt_o  output  1  transmitter empty (FSM idle, no frame in progress).
REQ-009 SHALL have port: sout_o  output  1  serial output, registered, idle high.

Function
REQ-010 SHALL implement FSM states ST_IDLE, ST_START, ST_BYTE, ST_PARITY, ST_STOP; illegal state -> ST_IDLE, sout_o=1.
REQ-011 SHALL advance the FSM and all counters only on clk_i edges with baudout_i=1.
REQ-012 SHALL run a 4-bit tick counter; every start, data and parity bit lasts exactly 16 baudout ticks.
REQ-013 ST_IDLE, tick, empty_i=0: SHALL go to ST_START, load d_i into the shift register, drive sout_o=0, and pulse pop_o=1 for exactly one clk_i cycle.
REQ-014 SHALL latch wls, pen, eps, stick_parity and stb at the ST_START load; CSR changes mid-frame SHALL NOT affect the current frame.
REQ-015 ST_BYTE: SHALL shift data LSB first, wls+5 bits (5..8); bits above the word length are ignored.
REQ-016 After the last data bit SHALL go to ST_PARITY if pen=1, else ST_STOP.
REQ-017 Parity bit {stick,eps}: 00 -> ~^data (odd); 01 -> ^data (even); 10 -> 1; 11 -> 0; data masked to word length.
REQ-018 ST_STOP: sout_o=1 for 16 ticks if stb=0; if stb=1, 24 ticks when wls=5 bits, else 32 ticks.
REQ-019 At end of ST_STOP: empty_i=0 -> SHALL go directly to ST_START per REQ-013 on the same tick with no idle gap; else -> ST_IDLE.
REQ-020 temt_o SHALL be 1 exactly when state=ST_IDLE.
REQ-021 lcr.bc=1 SHALL force sout_o=0 within one clk_i cycle regardless of state; the FSM keeps running, so a frame in progress completes internally and its bits are lost.
REQ-022 Releasing lcr.bc SHALL restore sout_o to the FSM-driven level on the next clk_i cycle.
REQ-023 pop_o SHALL never assert while empty_i=1, and SHALL assert at most once per frame.
REQ-024 When baudout_i=0 and no pop is due, pop_o SHALL be 0 and all outputs SHALL hold their values.

Reset
REQ-025 rst_i=1 at any clk_i edge SHALL set state=ST_IDLE, sout_o=1, pop_o=0 and temt_o=1, including mid-frame; the aborted frame is discarded and not re-popped.
REQ-026 Tick counter, bit counter and shift register reset values SHALL be don't-care; no output SHALL depend on them while in ST_IDLE.
REQ-027 The first frame after rst_i deasserts SHALL start only on a tick with empty_i=0.

Verification
REQ-028 baudout_i=1 every cycle, 8N1, d_i=0x55, single entry: one pop_o pulse; sout_o = 0 for 16 clk, then 1,0,1,0,1,0,1,0 for 16 clk each, then 1 for 16 clk; temt_o=1 after 160 clk.
REQ-029 7E1 (wls=7 bits, pen=1, eps=1), d_i=0x83: data bits 1,1,0,0,0,0,0 sent, bit 7 dropped; parity bit=0; 10 bit times total.
REQ-030 Two FIFO entries 0xA5 then 0x3C, 8N2: second start bit immediately follows 32-tick stop with no gap; exactly two pop_o pulses.
REQ-031 5N1.5 (wls=5 bits, stb=1), d_i=0x1F: stop lasts 24 ticks; stick parity {10} with pen=1 gives parity bit 1.
REQ-032 lcr.bc=1 mid-data-bit for 40 clk: sout_o=0 throughout; frame timing continues; temt_o rises at the nominal frame end.
REQ-033 rst_i pulsed at bit 4 of a frame with empty_i=0: next cycle sout_o=1, temt_o=1; after release a new frame starts and pop_o pulses once.

Source files
------------

// File: rtl/uart16550_tx.sv
// 16550-compatible transmit serializer: pops the TX FIFO head, frames it with
// start/data/parity/stop bits at 16 baudout ticks per bit, and supports break.
package uart16550_pkg;

  typedef struct packed {
    logic       dlab;
    logic       bc;
    logic       stick_parity;
    logic       eps;
    logic       pen;
    logic       stb;
    logic [1:0] wls;
  } lcr_t;

  typedef struct packed {
    lcr_t lcr;
  } csr_t;

endpackage

module uart16550_tx
  import uart16550_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       baudout_i,
  input  csr_t       csr_i,
  input  logic       empty_i,
  input  logic [7:0] d_i,
  output logic       pop_o,
  output logic       temt_o,
  output logic       sout_o
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_BYTE   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef struct packed {
    logic [1:0] wls;
    logic       stb;
    logic       pen;
  } frame_cfg_t;

  logic [2:0] state_reg, state_next;
  logic [3:0] tick_reg, tick_next;
  logic [2:0] bit_reg, bit_next;
  logic [7:0] shift_reg, shift_next;
  logic       parity_reg, parity_next;
  frame_cfg_t cfg_reg, cfg_next;
  logic       line_reg, line_next;
  logic       sout_reg;
  logic       load;

  logic [7:0] data_masked;
  logic       parity_calc;
  logic [2:0] last_bit;
  logic [4:0] stop_pos;
  logic [4:0] stop_last;
  logic       state_valid;
  logic       unused_csr;

  assign unused_csr = csr_i.lcr.dlab;

  // Bits above the configured word length never contribute to parity.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_mask
      assign data_masked[gi] = d_i[gi] & (3'(gi) <= ({1'b0, csr_i.lcr.wls} + 3'd4));
    end
  endgenerate

  assign parity_calc = csr_i.lcr.stick_parity ? ~csr_i.lcr.eps
                     : (csr_i.lcr.eps ? ^data_masked : ~^data_masked);

  assign last_bit    = {1'b0, cfg_reg.wls} + 3'd4;
  // Stop phase uses bit_reg[0] as a fifth tick-count bit to reach 24/32 ticks.
  assign stop_pos    = {bit_reg[0], tick_reg};
  assign stop_last   = !cfg_reg.stb ? 5'd15 : ((cfg_reg.wls == 2'd0) ? 5'd23 : 5'd31);
  assign state_valid = (state_reg <= ST_STOP);

  always_comb begin
    state_next  = state_reg;
    tick_next   = tick_reg;
    bit_next    = bit_reg;
    shift_next  = shift_reg;
    parity_next = parity_reg;
    cfg_next    = cfg_reg;
    line_next   = line_reg;
    load        = 1'b0;

    if (!state_valid) begin
      state_next = ST_IDLE;
      line_next  = 1'b1;
    end else if (baudout_i) begin
      tick_next = tick_reg + 4'd1;
      case (state_reg)
        ST_IDLE: begin
          line_next = 1'b1;
          load      = ~empty_i;
        end
        ST_START: begin
          if (tick_reg == 4'd15) begin
            state_next = ST_BYTE;
            bit_next   = 3'd0;
            line_next  = shift_reg[0];
          end
        end
        ST_BYTE: begin
          if (tick_reg == 4'd15) begin
            if (bit_reg == last_bit) begin
              if (cfg_reg.pen) begin
                state_next = ST_PARITY;
                line_next  = parity_reg;
              end else begin
                state_next = ST_STOP;
                bit_next   = 3'd0;
                line_next  = 1'b1;
              end
            end else begin
              bit_next   = bit_reg + 3'd1;
              shift_next = {1'b0, shift_reg[7:1]};
              line_next  = shift_reg[1];
            end
          end
        end
        ST_PARITY: begin
          if (tick_reg == 4'd15) begin
            state_next = ST_STOP;
            bit_next   = 3'd0;
            line_next  = 1'b1;
          end
        end
        ST_STOP: begin
          line_next = 1'b1;
          if (stop_pos == stop_last) begin
            if (empty_i) begin
              state_next = ST_IDLE;
            end else begin
              load = 1'b1;
            end
          end else if (tick_reg == 4'd15) begin
            bit_next = 3'd1;
          end
        end
        default: begin
          state_next = ST_IDLE;
          line_next  = 1'b1;
        end
      endcase

      // Back-to-back frames reload straight from the stop phase, no idle gap.
      if (load) begin
        state_next   = ST_START;
        tick_next    = 4'd0;
        shift_next   = d_i;
        parity_next  = parity_calc;
        cfg_next.wls = csr_i.lcr.wls;
        cfg_next.stb = csr_i.lcr.stb;
        cfg_next.pen = csr_i.lcr.pen;
        line_next    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
      line_reg  <= 1'b1;
      sout_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      line_reg  <= line_next;
      sout_reg  <= csr_i.lcr.bc ? 1'b0 : line_next;
    end
  end

  // Datapath state is only meaningful once a frame has been loaded.
  always_ff @(posedge clk_i) begin
    tick_reg   <= tick_next;
    bit_reg    <= bit_next;
    shift_reg  <= shift_next;
    parity_reg <= parity_next;
    cfg_reg    <= cfg_next;
  end

  assign pop_o  = load & ~rst_i;
  assign temt_o = (state_reg == ST_IDLE);
  assign sout_o = sout_reg;

endmodule

// File: tb/tb_uart16550_tx.sv
// Self-checking bench for uart16550_tx: FIFO model plus per-cycle serial scoreboard.
module tb_uart16550_tx;
  import uart16550_pkg::*;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       baudout_i;
  csr_t       csr_i;
  logic       empty_i;
  logic [7:0] d_i;
  logic       pop_o;
  logic       temt_o;
  logic       sout_o;

  always #5 clk = ~clk;

  uart16550_tx dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .baudout_i (baudout_i),
    .csr_i     (csr_i),
    .empty_i   (empty_i),
    .d_i       (d_i),
    .pop_o     (pop_o),
    .temt_o    (temt_o),
    .sout_o    (sout_o)
  );

  typedef struct {
    int         wls;
    int         stb;
    int         pen;
    int         eps;
    int         stick;
    int         period;
    int         nbytes;
    logic [7:0] d0;
    logic [7:0] d1;
    int         exp_busy;
  } vec_t;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] fifo_q[$];
  bit         exp_q[$];
  bit         armed     = 1'b0;
  bit         bc_eff    = 1'b0;
  int         baud_period = 1;
  int         baud_cnt  = 0;
  int         busy_cnt  = 0;
  int         pop_cnt   = 0;
  bit         last_temt = 1'b0;
  bit         last_sout = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
  endtask

  task automatic drive_fifo();
    empty_i = (fifo_q.size() == 0);
    d_i     = empty_i ? 8'h00 : fifo_q[0];
  endtask

  // Expected per-clock sout levels for one frame, using the CSR seen at pop time.
  function automatic void build_frame(input logic [7:0] d);
    int nb, reps, stop_ticks, ones;
    bit par;
    nb   = int'(csr_i.lcr.wls) + 5;
    reps = 16 * baud_period;
    ones = 0;
    for (int i = 0; i < reps; i++) exp_q.push_back(1'b0);
    for (int b = 0; b < nb; b++) begin
      ones += int'(d[b]);
      for (int i = 0; i < reps; i++) exp_q.push_back(d[b]);
    end
    if (csr_i.lcr.pen) begin
      if (csr_i.lcr.stick_parity) par = !csr_i.lcr.eps;
      else if (csr_i.lcr.eps)     par = (ones % 2) == 1;
      else                        par = (ones % 2) == 0;
      for (int i = 0; i < reps; i++) exp_q.push_back(par);
    end
    if (!csr_i.lcr.stb)             stop_ticks = 16;
    else if (csr_i.lcr.wls == 2'd0) stop_ticks = 24;
    else                            stop_ticks = 32;
    for (int i = 0; i < stop_ticks * baud_period; i++) exp_q.push_back(1'b1);
  endfunction

  task automatic cycle();
    bit s_pop, s_temt, s_sout, pop_legal, exp_s, rst_edge;
    @(negedge clk);
    s_pop  = pop_o;
    s_temt = temt_o;
    s_sout = sout_o;
    last_temt = s_temt;
    last_sout = s_sout;
    if (!s_temt) busy_cnt++;
    pop_legal = baudout_i && !empty_i && !rst_i;
    check("pop_gate", int'(s_pop && !pop_legal), 0);
    if (armed) begin
      exp_s = exp_q.pop_front();
      if (bc_eff) exp_s = 1'b0;
      check("sout_frame", int'(s_sout), int'(exp_s));
      check("temt_busy", int'(s_temt), 0);
      if (exp_q.size() == 0) armed = 1'b0;
    end else begin
      check("sout_idle", int'(s_sout), bc_eff ? 0 : 1);
      check("temt_idle", int'(s_temt), 1);
    end
    if (s_pop && pop_legal) begin
      pop_cnt++;
      build_frame(fifo_q[0]);
      armed = 1'b1;
    end
    @(posedge clk);
    rst_edge = rst_i;
    bc_eff   = csr_i.lcr.bc;
    #1;
    if (rst_edge) begin
      exp_q.delete();
      armed = 1'b0;
    end else if (s_pop && pop_legal) begin
      void'(fifo_q.pop_front());
    end
    if (baud_period <= 1) baud_cnt = 0;
    else baud_cnt = (baud_cnt + 1) % baud_period;
    baudout_i = (baud_cnt == 0);
    drive_fifo();
  endtask

  task automatic run_until_idle(input int bound);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < bound) begin
      cycle();
      n++;
      done = (fifo_q.size() == 0) && !armed && last_temt;
    end
    check("idle_reached", int'(done), 1);
  endtask

  task automatic set_cfg(input int wls, input int stb, input int pen, input int eps, input int stick);
    csr_i                  = '0;
    csr_i.lcr.wls          = 2'(wls);
    csr_i.lcr.stb          = 1'(stb);
    csr_i.lcr.pen          = 1'(pen);
    csr_i.lcr.eps          = 1'(eps);
    csr_i.lcr.stick_parity = 1'(stick);
  endtask

  vec_t vecs[8];
  int   p0;

  initial begin
    vecs[0] = '{3, 0, 0, 0, 0, 1, 1, 8'h55, 8'h00, 160};  // 8N1
    vecs[1] = '{2, 0, 1, 1, 0, 1, 1, 8'h83, 8'h00, 160};  // 7E1, bit 7 dropped
    vecs[2] = '{3, 1, 0, 0, 0, 1, 2, 8'hA5, 8'h3C, 352};  // 8N2 back-to-back
    vecs[3] = '{0, 1, 1, 0, 1, 1, 1, 8'h1F, 8'h00, 136};  // 5 bits, stick 1, 1.5 stop
    vecs[4] = '{1, 0, 1, 0, 0, 3, 1, 8'h2A, 8'h00, 432};  // 6O1, tick every 3 clk
    vecs[5] = '{3, 1, 1, 1, 1, 1, 1, 8'h00, 8'h00, 192};  // 8 bits, stick 0, 2 stop
    vecs[6] = '{0, 0, 1, 0, 0, 2, 2, 8'hE0, 8'h07, 512};  // 5O1 masked data, tick/2
    vecs[7] = '{2, 1, 0, 0, 0, 1, 1, 8'hFF, 8'h00, 160};  // 7N2

    rst_i     = 1'b1;
    baudout_i = 1'b1;
    csr_i     = '0;
    empty_i   = 1'b1;
    d_i       = 8'h00;
    @(posedge clk);
    #1;
    repeat (2) cycle();

    // Data waiting during reset must not be popped; first frame follows release.
    fifo_q.push_back(8'h99);
    drive_fifo();
    repeat (3) cycle();
    check("rst_no_pop", pop_cnt, 0);
    rst_i    = 1'b0;
    busy_cnt = 0;
    run_until_idle(2000);
    check("post_rst_busy", busy_cnt, 112);
    check("post_rst_pops", pop_cnt, 1);

    for (int v = 0; v < 8; v++) begin
      set_cfg(vecs[v].wls, vecs[v].stb, vecs[v].pen, vecs[v].eps, vecs[v].stick);
      baud_period = vecs[v].period;
      busy_cnt    = 0;
      p0          = pop_cnt;
      fifo_q.push_back(vecs[v].d0);
      if (vecs[v].nbytes > 1) fifo_q.push_back(vecs[v].d1);
      drive_fifo();
      run_until_idle(4000);
      $display("vec %0d: d0=%02h busy=%0d pops=%0d", v, vecs[v].d0, busy_cnt, pop_cnt - p0);
      check("vec_busy", busy_cnt, vecs[v].exp_busy);
      check("vec_pops", pop_cnt - p0, vecs[v].nbytes);
      repeat (3) cycle();
    end

    // Break mid data bit, with a CSR change that must not touch the current frame.
    set_cfg(3, 0, 0, 0, 0);
    baud_period = 1;
    busy_cnt    = 0;
    p0          = pop_cnt;
    fifo_q.push_back(8'h55);
    drive_fifo();
    repeat (41) cycle();
    csr_i.lcr.bc  = 1'b1;
    csr_i.lcr.wls = 2'd0;
    csr_i.lcr.pen = 1'b1;
    repeat (40) cycle();
    csr_i.lcr.bc = 1'b0;
    run_until_idle(2000);
    $display("break: busy=%0d pops=%0d", busy_cnt, pop_cnt - p0);
    check("break_busy", busy_cnt, 160);
    check("break_pops", pop_cnt - p0, 1);
    repeat (3) cycle();

    // Reset during data bit 4 with a second entry still queued.
    set_cfg(3, 0, 0, 0, 0);
    baud_period = 1;
    p0          = pop_cnt;
    fifo_q.push_back(8'h11);
    fifo_q.push_back(8'h22);
    drive_fifo();
    repeat (89) cycle();
    rst_i       = 1'b1;
    baud_period = 4;
    cycle();
    rst_i = 1'b0;
    busy_cnt = 0;
    cycle();
    check("rst_mid_sout", int'(last_sout), 1);
    check("rst_mid_temt", int'(last_temt), 1);
    run_until_idle(3000);
    $display("reset: busy=%0d pops=%0d", busy_cnt, pop_cnt - p0);
    check("rst_mid_busy", busy_cnt, 640);
    check("rst_mid_pops", pop_cnt - p0, 2);
    repeat (3) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
